// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcodes, flag indices, cond codes and FSM states
package alu_op_sequencer_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;
  localparam logic [2:0] OP_COMP = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  // Flags are packed {C,N,O,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;
  localparam logic [2:0] COND_N      = 3'd5;
  localparam logic [2:0] COND_O      = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_cond_eval.sv
// rtl/alu_op_sequencer_cond_eval.sv - combinational branch condition over {C,N,O,Z}
module alu_cond_eval
  import alu_op_sequencer_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_true_o
);

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      COND_ALWAYS: cond_true_o = 1'b1;
      COND_Z:      cond_true_o = flags_i[FLAG_Z];
      COND_NZ:     cond_true_o = ~flags_i[FLAG_Z];
      COND_C:      cond_true_o = flags_i[FLAG_C];
      COND_NC:     cond_true_o = ~flags_i[FLAG_C];
      COND_N:      cond_true_o = flags_i[FLAG_N];
      COND_O:      cond_true_o = flags_i[FLAG_O];
      COND_NEVER:  cond_true_o = 1'b0;
      default:     cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives one ALU operation, captures result/flags, evaluates cond
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_start,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_cond,
  output logic              out_ready,
  output logic              out_done,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              out_cond_true,
  output logic [DATA_W-1:0] out_alu_a,
  output logic [DATA_W-1:0] out_alu_b,
  output logic [2:0]        out_alu_op,
  output logic              out_alu_enable_out,
  output logic              out_alu_bus_owned,
  input  logic [DATA_W-1:0] in_alu_bus,
  input  logic [3:0]        in_alu_flags
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic [2:0]        alu_op_q, cond_q;
  logic [3:0]        flags_q;
  logic              cond_true_q;
  logic              accept, capture, cond_eval;

  alu_cond_eval u_cond_eval (
    .cond_i      (cond_q),
    .flags_i     (in_alu_flags),
    .cond_true_o (cond_eval)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (in_start) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_READ;
        cnt_d   = SETTLE_INIT;
      end
      ST_READ: begin
        // Extra READ cycles let the bus and flags settle before sampling
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'd0;
      cond_q      <= 3'd0;
      result_q    <= '0;
      flags_q     <= 4'd0;
      cond_true_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        alu_a_q  <= in_a;
        alu_b_q  <= in_b;
        alu_op_q <= in_op;
        cond_q   <= in_cond;
      end
      if (capture) begin
        result_q    <= in_alu_bus;
        flags_q     <= in_alu_flags;
        cond_true_q <= cond_eval;
      end
    end
  end

  assign out_ready          = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign out_done           = (state_q == ST_DONE);
  assign out_alu_enable_out = (state_q != ST_EXEC);
  assign out_alu_bus_owned  = (state_q == ST_READ);
  assign out_result         = result_q;
  assign out_flags          = flags_q;
  assign out_cond_true      = cond_true_q;
  assign out_alu_a          = alu_a_q;
  assign out_alu_b          = alu_b_q;
  assign out_alu_op         = alu_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench with a behavioural ALU behind each sequencer
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op, cond;
  logic [7:0] a, b;
  logic       start0, start1;

  logic       ready0, done0, ct0, en0, own0;
  logic [7:0] res0, alu_a0, alu_b0, bus0, alu_r0;
  logic [3:0] flg0, aflg0;
  logic [2:0] alu_op0;

  logic       ready1, done1, ct1, en1, own1;
  logic [7:0] res1, alu_a1, alu_b1, bus1, alu_r1;
  logic [3:0] flg1, aflg1;
  logic [2:0] alu_op1;

  int checks = 0;
  int errors = 0;
  int lat, en_low, owned;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_calc(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: alu_calc = x + y;
      3'd1: alu_calc = x - y;
      3'd2: alu_calc = x | y;
      3'd3: alu_calc = x & y;
      3'd4: alu_calc = ~x;
      3'd5: alu_calc = (x == y) ? 8'h01 : 8'h00;
      3'd6: alu_calc = x >> 1;
      default: alu_calc = x << 1;
    endcase
  endfunction

  function automatic logic [3:0] alu_flags(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                           input logic [7:0] r);
    logic [8:0] sum;
    logic c, v;
    sum = {1'b0, x} + {1'b0, y};
    c = 1'b0;
    v = 1'b0;
    if (o == 3'd0) begin
      c = sum[8];
      v = (x[7] == y[7]) && (r[7] != x[7]);
    end else if (o == 3'd1) begin
      c = (x < y);
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
    alu_flags = {c, r[7], v, (r == 8'h00)};
  endfunction

  always @(posedge clk) if (!en0) alu_r0 <= alu_calc(alu_op0, alu_a0, alu_b0);
  always @(posedge clk) if (!en1) alu_r1 <= alu_calc(alu_op1, alu_a1, alu_b1);
  assign bus0  = own0 ? alu_r0 : 8'h00;
  assign bus1  = own1 ? alu_r1 : 8'h00;
  assign aflg0 = alu_flags(alu_op0, alu_a0, alu_b0, alu_r0);
  assign aflg1 = alu_flags(alu_op1, alu_a1, alu_b1, alu_r1);

  alu_op_sequencer #(.DATA_W(8), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_start(start0), .in_op(op), .in_a(a), .in_b(b), .in_cond(cond),
    .out_ready(ready0), .out_done(done0), .out_result(res0), .out_flags(flg0), .out_cond_true(ct0),
    .out_alu_a(alu_a0), .out_alu_b(alu_b0), .out_alu_op(alu_op0), .out_alu_enable_out(en0),
    .out_alu_bus_owned(own0), .in_alu_bus(bus0), .in_alu_flags(aflg0)
  );

  alu_op_sequencer #(.DATA_W(8), .SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .in_start(start1), .in_op(op), .in_a(a), .in_b(b), .in_cond(cond),
    .out_ready(ready1), .out_done(done1), .out_result(res1), .out_flags(flg1), .out_cond_true(ct1),
    .out_alu_a(alu_a1), .out_alu_b(alu_b1), .out_alu_op(alu_op1), .out_alu_enable_out(en1),
    .out_alu_bus_owned(own1), .in_alu_bus(bus1), .in_alu_flags(aflg1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op from IDLE/DONE and returns at the negedge where done is first seen
  task automatic run_op(input bit sel, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] c, output int l, output int el, output int ow);
    @(negedge clk);
    op = o; a = x; b = y; cond = c;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    l = 1; el = 0; ow = 0;
    while (l < 40) begin
      if (sel ? done1 : done0) break;
      if (!(sel ? en1 : en0)) el++;
      if (sel ? own1 : own0) ow++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    op = 3'd0; a = 8'h00; b = 8'h00; cond = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_en", {31'd0, en0}, 32'd1);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_own", {31'd0, own0}, 32'd0);
    chk("rst_result", {24'd0, res0}, 32'h00);
    chk("rst_flags", {28'd0, flg0}, 32'h0);
    chk("rst_cond", {31'd0, ct0}, 32'd0);
    chk("rst_alu_ab", {16'd0, alu_a0, alu_b0}, 32'h0);
    chk("rst_ready1", {31'd0, ready1}, 32'd1);
    reset = 1'b0;

    // 1: ADD overflow into sign bit, cond O
    run_op(1'b0, 3'd0, 8'h7F, 8'h01, 3'd6, lat, en_low, owned);
    chk("t1_lat", lat, 32'd3);
    chk("t1_en_low", en_low, 32'd1);
    chk("t1_result", {24'd0, res0}, 32'h80);
    chk("t1_flags", {28'd0, flg0}, 32'h6);
    chk("t1_cond", {31'd0, ct0}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_idle_hold_a", {24'd0, alu_a0}, 32'h7F);
    chk("t1_idle_ready", {31'd0, ready0}, 32'd1);

    // 2: SUB borrow, cond C
    run_op(1'b0, 3'd1, 8'h00, 8'h01, 3'd3, lat, en_low, owned);
    chk("t2_lat", lat, 32'd3);
    chk("t2_result", {24'd0, res0}, 32'hFF);
    chk("t2_flags", {28'd0, flg0}, 32'hC);
    chk("t2_cond", {31'd0, ct0}, 32'd1);

    // 3: COMP equal, cond Z on nonzero result
    @(negedge clk);
    run_op(1'b0, 3'd5, 8'h55, 8'h55, 3'd1, lat, en_low, owned);
    chk("t3_result", {24'd0, res0}, 32'h01);
    chk("t3_flags", {28'd0, flg0}, 32'h0);
    chk("t3_cond", {31'd0, ct0}, 32'd0);
    chk("t3_en_low", en_low, 32'd1);
    chk("t3_owned", owned, 32'd1);

    // 4: starts in EXEC/READ ignored; start in DONE goes straight to EXEC
    @(negedge clk);
    op = 3'd0; a = 8'h01; b = 8'h01; cond = 3'd0; start0 = 1'b1;
    @(negedge clk);
    a = 8'h09; b = 8'h09;
    chk("t4_exec_en", {31'd0, en0}, 32'd0);
    @(negedge clk);
    chk("t4_read_ready", {31'd0, ready0}, 32'd0);
    chk("t4_read_done", {31'd0, done0}, 32'd0);
    chk("t4_read_a", {24'd0, alu_a0}, 32'h01);
    @(negedge clk);
    chk("t4_done", {31'd0, done0}, 32'd1);
    chk("t4_result", {24'd0, res0}, 32'h02);
    chk("t4_cond", {31'd0, ct0}, 32'd1);
    a = 8'h03; b = 8'h04; cond = 3'd4;
    @(negedge clk);
    start0 = 1'b0;
    chk("t4_b2b_en", {31'd0, en0}, 32'd0);
    chk("t4_b2b_done", {31'd0, done0}, 32'd0);
    chk("t4_b2b_ab", {16'd0, alu_a0, alu_b0}, 32'h0304);
    @(negedge clk);
    @(negedge clk);
    chk("t4_b2b_done2", {31'd0, done0}, 32'd1);
    chk("t4_b2b_result", {24'd0, res0}, 32'h07);
    chk("t4_b2b_cond", {31'd0, ct0}, 32'd1);

    // 5: reset during EXEC
    @(negedge clk);
    op = 3'd0; a = 8'h10; b = 8'h20; cond = 3'd0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("t5_in_exec", {31'd0, en0}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_ready", {31'd0, ready0}, 32'd1);
    chk("t5_en", {31'd0, en0}, 32'd1);
    chk("t5_done", {31'd0, done0}, 32'd0);
    chk("t5_result", {24'd0, res0}, 32'h00);
    chk("t5_flags", {28'd0, flg0}, 32'h0);
    @(negedge clk);
    chk("t5_no_done", {31'd0, done0}, 32'd0);
    run_op(1'b0, 3'd0, 8'h02, 8'h03, 3'd2, lat, en_low, owned);
    chk("t5_lat", lat, 32'd3);
    chk("t5_result2", {24'd0, res0}, 32'h05);
    chk("t5_cond2", {31'd0, ct0}, 32'd1);

    // 6: two settle cycles, SHL drops the top bit, cond never
    run_op(1'b1, 3'd7, 8'h81, 8'h00, 3'd7, lat, en_low, owned);
    chk("t6_lat", lat, 32'd5);
    chk("t6_owned", owned, 32'd3);
    chk("t6_en_low", en_low, 32'd1);
    chk("t6_result", {24'd0, res1}, 32'h02);
    chk("t6_flags", {28'd0, flg1}, 32'h0);
    chk("t6_cond", {31'd0, ct1}, 32'd0);
    @(negedge clk);
    chk("t6_idle", {30'd0, done1, ready1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
